// File: rtl/asic_freq_counter.sv
// Frequency counter: gated periodic edge count, free-running edge count,
// UART result stream and a 9-column multiplexed 7-segment driver.
module asic_freq_counter #(
  parameter int unsigned DEF_DIV    = 434,
  parameter int unsigned DEF_PERIOD = 10000000,
  parameter int unsigned SCAN_DIV   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  addr,
  input  logic [31:0] value,
  input  logic        strobe,
  input  logic        samplee,
  output logic [31:0] o,
  output logic [31:0] oc,
  output logic        tx,
  output logic [8:0]  col_drvs,
  output logic [7:0]  seg_drvs
);

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV + 1);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;

  // Configuration registers
  logic [15:0] div_q, div_d;
  logic [31:0] period_q, period_d;
  logic        mode_q, mode_d;
  logic [31:0] digits_q, digits_d;
  logic [3:0]  digit8_q, digit8_d;
  logic [8:0]  dp_q, dp_d;

  // Input path and counters
  logic        s1_q, s2_q, s3_q;
  logic        edge_w;
  logic [31:0] timer_q, timer_d;
  logic [31:0] pcount_q, pcount_d;
  logic [31:0] o_q, o_d;
  logic [31:0] oc_q, oc_d;
  logic        update_q, update_d;
  logic        per_wr;
  logic        terminal;

  // UART
  uart_state_e ustate_q, ustate_d;
  logic [15:0] ucnt_q, ucnt_d;
  logic [15:0] udiv_q, udiv_d;
  logic [2:0]  ubit_q, ubit_d;
  logic [1:0]  ubyte_q, ubyte_d;
  logic [31:0] uword_q, uword_d;
  logic        tx_q, tx_d;
  logic        bit_end;
  logic [7:0]  cur_byte;

  // Display
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [3:0]        col_q, col_d;
  logic [8:0]        col_drvs_q, col_drvs_d;
  logic [7:0]        seg_drvs_q, seg_drvs_d;
  logic [31:0]       disp_src;
  logic [31:0]       disp_shift;
  logic [3:0]        nib;

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0: hex_font = 7'h3F;
      4'h1: hex_font = 7'h06;
      4'h2: hex_font = 7'h5B;
      4'h3: hex_font = 7'h4F;
      4'h4: hex_font = 7'h66;
      4'h5: hex_font = 7'h6D;
      4'h6: hex_font = 7'h7D;
      4'h7: hex_font = 7'h07;
      4'h8: hex_font = 7'h7F;
      4'h9: hex_font = 7'h6F;
      4'hA: hex_font = 7'h77;
      4'hB: hex_font = 7'h7C;
      4'hC: hex_font = 7'h39;
      4'hD: hex_font = 7'h5E;
      4'hE: hex_font = 7'h79;
      default: hex_font = 7'h71;
    endcase
  endfunction

  // Synchronizer plus one extra stage for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= samplee;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_w = s2_q & ~s3_q;

  // Register writes, gate timer and both edge counters
  always_comb begin
    div_d    = div_q;
    period_d = period_q;
    mode_d   = mode_q;
    digits_d = digits_q;
    digit8_d = digit8_q;
    dp_d     = dp_q;
    per_wr   = 1'b0;
    if (strobe) begin
      case (addr)
        4'd0: div_d = (value[15:0] < 16'd4) ? 16'd4 : value[15:0];
        4'd1: begin
          period_d = (value == '0) ? 32'd1 : value;
          per_wr   = 1'b1;
        end
        4'd2: mode_d   = value[0];
        4'd3: digits_d = value;
        4'd4: digit8_d = value[3:0];
        4'd5: dp_d     = value[8:0];
        default: ;
      endcase
    end

    terminal = (timer_q == period_q - 32'd1);
    o_d      = o_q;
    update_d = 1'b0;
    oc_d     = oc_q + {31'd0, edge_w};
    if (per_wr) begin
      timer_d  = '0;
      pcount_d = '0;
    end else if (terminal) begin
      o_d      = pcount_q + {31'd0, edge_w};
      pcount_d = '0;
      timer_d  = '0;
      update_d = 1'b1;
    end else begin
      timer_d  = timer_q + 32'd1;
      pcount_d = pcount_q + {31'd0, edge_w};
    end
  end

  // Configuration and counter state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= 16'(DEF_DIV);
      period_q <= 32'(DEF_PERIOD);
      mode_q   <= 1'b0;
      digits_q <= '0;
      digit8_q <= '0;
      dp_q     <= '0;
      timer_q  <= '0;
      pcount_q <= '0;
      o_q      <= '0;
      oc_q     <= '0;
      update_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      digits_q <= digits_d;
      digit8_q <= digit8_d;
      dp_q     <= dp_d;
      timer_q  <= timer_d;
      pcount_q <= pcount_d;
      o_q      <= o_d;
      oc_q     <= oc_d;
      update_q <= update_d;
    end
  end

  // UART next-state: 4 bytes MSB first, each start/8 data LSB first/stop
  always_comb begin
    ustate_d = ustate_q;
    ucnt_d   = ucnt_q;
    udiv_d   = udiv_q;
    ubit_d   = ubit_q;
    ubyte_d  = ubyte_q;
    uword_d  = uword_q;
    tx_d     = tx_q;
    bit_end  = (ucnt_q == udiv_q - 16'd1);
    cur_byte = uword_q[31:24];
    case (ustate_q)
      U_IDLE: begin
        tx_d = 1'b1;
        if (update_q) begin
          uword_d  = o_q;
          udiv_d   = div_q;
          ucnt_d   = '0;
          ubyte_d  = '0;
          ustate_d = U_START;
          tx_d     = 1'b0;
        end
      end
      U_START: begin
        if (bit_end) begin
          ucnt_d   = '0;
          ubit_d   = '0;
          ustate_d = U_DATA;
          tx_d     = cur_byte[0];
        end else begin
          ucnt_d = ucnt_q + 16'd1;
        end
      end
      U_DATA: begin
        if (bit_end) begin
          ucnt_d = '0;
          if (ubit_q == 3'd7) begin
            ustate_d = U_STOP;
            tx_d     = 1'b1;
          end else begin
            ubit_d = ubit_q + 3'd1;
            tx_d   = cur_byte[ubit_q + 3'd1];
          end
        end else begin
          ucnt_d = ucnt_q + 16'd1;
        end
      end
      default: begin
        if (bit_end) begin
          ucnt_d = '0;
          if (ubyte_q == 2'd3) begin
            ustate_d = U_IDLE;
            tx_d     = 1'b1;
          end else begin
            ubyte_d  = ubyte_q + 2'd1;
            uword_d  = {uword_q[23:0], 8'h00};
            ustate_d = U_START;
            tx_d     = 1'b0;
          end
        end else begin
          ucnt_d = ucnt_q + 16'd1;
        end
      end
    endcase
  end

  // UART state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ustate_q <= U_IDLE;
      ucnt_q   <= '0;
      udiv_q   <= 16'(DEF_DIV);
      ubit_q   <= '0;
      ubyte_q  <= '0;
      uword_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      ustate_q <= ustate_d;
      ucnt_q   <= ucnt_d;
      udiv_q   <= udiv_d;
      ubit_q   <= ubit_d;
      ubyte_q  <= ubyte_d;
      uword_q  <= uword_d;
      tx_q     <= tx_d;
    end
  end

  // Display scan and segment decode; column and segments registered together
  always_comb begin
    scan_d = scan_q + SCAN_W'(1);
    col_d  = col_q;
    if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_d = '0;
      col_d  = (col_q == 4'd8) ? 4'd0 : col_q + 4'd1;
    end
    disp_src   = mode_q ? digits_q : o_q;
    disp_shift = disp_src >> {col_q[2:0], 2'b00};
    if (col_q == 4'd8) begin
      nib = mode_q ? digit8_q : 4'h0;
    end else begin
      nib = disp_shift[3:0];
    end
    seg_drvs_d = {dp_q[col_q], hex_font(nib)};
    col_drvs_d = 9'd1 << col_q;
  end

  // Display state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q     <= '0;
      col_q      <= '0;
      col_drvs_q <= 9'd1;
      seg_drvs_q <= 8'h3F;
    end else begin
      scan_q     <= scan_d;
      col_q      <= col_d;
      col_drvs_q <= col_drvs_d;
      seg_drvs_q <= seg_drvs_d;
    end
  end

  assign o        = o_q;
  assign oc       = oc_q;
  assign tx       = tx_q;
  assign col_drvs = col_drvs_q;
  assign seg_drvs = seg_drvs_q;

endmodule

// File: tb/tb_asic_freq_counter.sv
// Directed bench for asic_freq_counter with a 4-clock display scan.
module tb_asic_freq_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  addr = '0;
  logic [31:0] value = '0;
  logic        strobe = 1'b0;
  logic        samplee = 1'b0;
  logic [31:0] o, oc;
  logic        tx;
  logic [8:0]  col_drvs;
  logic [7:0]  seg_drvs;

  int n_checks = 0;
  int n_fail = 0;

  logic gen_en = 1'b0;
  logic gen_val = 1'b0;
  logic man_val = 1'b0;
  int   gen_half = 5;
  int   gcnt = 0;

  typedef struct {
    logic       mode;
    logic [8:0] col;
    logic [7:0] seg;
  } disp_vec_t;

  disp_vec_t tbl[19];

  always #5 clk = ~clk;

  asic_freq_counter #(
    .DEF_DIV(434),
    .DEF_PERIOD(10000000),
    .SCAN_DIV(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .value(value),
    .strobe(strobe),
    .samplee(samplee),
    .o(o),
    .oc(oc),
    .tx(tx),
    .col_drvs(col_drvs),
    .seg_drvs(seg_drvs)
  );

  // Sole driver of samplee: square wave generator or manual level
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (gen_en) begin
        if (gcnt >= gen_half - 1) begin
          gcnt = 0;
          gen_val = ~gen_val;
        end else begin
          gcnt++;
        end
      end
      samplee = gen_en ? gen_val : man_val;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] v);
    @(posedge clk);
    #1;
    addr = a;
    value = v;
    strobe = 1'b1;
    @(posedge clk);
    #1;
    strobe = 1'b0;
  endtask

  task automatic wait_tx_low(input int bound, output logic found);
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Find a start bit preceded by at least 20 idle clocks
  task automatic wait_frame_start(input int bound, output logic found);
    int run;
    run = 0;
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (tx === 1'b1) begin
        run++;
      end else begin
        if (run >= 20) begin
          found = 1'b1;
          break;
        end
        run = 0;
      end
    end
  endtask

  // Entered half a clock into the start bit; samples at 4 clocks per bit
  task automatic uart_rx(output logic [31:0] w, output logic frame_ok);
    logic [7:0] b;
    int k;
    w = '0;
    b = '0;
    frame_ok = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      if (i > 0) repeat (4) @(negedge clk);
      k = i % 10;
      if (k == 0) begin
        if (tx !== 1'b0) frame_ok = 1'b0;
      end else if (k == 9) begin
        if (tx !== 1'b1) frame_ok = 1'b0;
        w = {w[23:0], b};
      end else begin
        b[k-1] = tx;
      end
    end
  endtask

  task automatic run_display(input logic m);
    logic [8:0] prev;
    logic found;
    logic first;
    prev = col_drvs;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (prev != 9'h001 && col_drvs == 9'h001) begin
        found = 1'b1;
        break;
      end
      prev = col_drvs;
    end
    check("disp_sync", {31'd0, found}, 32'd1);
    first = 1'b1;
    for (int i = 0; i < 19; i++) begin
      if (tbl[i].mode == m) begin
        if (!first) repeat (4) @(negedge clk);
        first = 1'b0;
        check($sformatf("disp_col m%0d i%0d", m, i), {23'd0, col_drvs}, {23'd0, tbl[i].col});
        check($sformatf("disp_seg m%0d i%0d", m, i), {24'd0, seg_drvs}, {24'd0, tbl[i].seg});
      end
    end
  endtask

  initial begin
    logic [31:0] w;
    logic ok;
    logic found;
    logic bad;
    logic [31:0] oc_a;

    // mode 0 with o = 0x000001F4, dp = 0
    tbl[0]  = '{1'b0, 9'h001, 8'h66};
    tbl[1]  = '{1'b0, 9'h002, 8'h71};
    tbl[2]  = '{1'b0, 9'h004, 8'h06};
    tbl[3]  = '{1'b0, 9'h008, 8'h3F};
    tbl[4]  = '{1'b0, 9'h010, 8'h3F};
    tbl[5]  = '{1'b0, 9'h020, 8'h3F};
    tbl[6]  = '{1'b0, 9'h040, 8'h3F};
    tbl[7]  = '{1'b0, 9'h080, 8'h3F};
    tbl[8]  = '{1'b0, 9'h100, 8'h3F};
    // mode 1 with digits 0x76543210, digit8 = 8, dp = 0x101
    tbl[9]  = '{1'b1, 9'h001, 8'hBF};
    tbl[10] = '{1'b1, 9'h002, 8'h06};
    tbl[11] = '{1'b1, 9'h004, 8'h5B};
    tbl[12] = '{1'b1, 9'h008, 8'h4F};
    tbl[13] = '{1'b1, 9'h010, 8'h66};
    tbl[14] = '{1'b1, 9'h020, 8'h6D};
    tbl[15] = '{1'b1, 9'h040, 8'h7D};
    tbl[16] = '{1'b1, 9'h080, 8'h07};
    tbl[17] = '{1'b1, 9'h100, 8'hFF};
    tbl[18] = '{1'b1, 9'h001, 8'hBF};

    // Reset defaults
    repeat (3) @(negedge clk);
    check("rst_o", o, 32'd0);
    check("rst_oc", oc, 32'd0);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_col", {23'd0, col_drvs}, 32'h001);
    check("rst_seg", {24'd0, seg_drvs}, 32'h3F);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // div below minimum is stored as 4
    wr(4'd0, 32'd2);

    // First edge latency
    repeat (5) @(negedge clk);
    man_val = 1'b1;
    @(posedge clk);
    #2;
    repeat (2) @(posedge clk);
    #2;
    check("edge_lat_2clk", oc, 32'd0);
    @(posedge clk);
    #2;
    check("edge_lat_3clk", oc, 32'd1);
    man_val = 1'b0;

    // Periodic count: rise every 10 clocks, period 100
    gen_val = 1'b0;
    gcnt = 0;
    gen_half = 5;
    gen_en = 1'b1;
    repeat (20) @(negedge clk);
    wr(4'd1, 32'd100);
    repeat (250) @(negedge clk);
    check("period100_o", o, 32'd10);
    oc_a = oc;
    repeat (100) @(negedge clk);
    check("oc_delta100", oc - oc_a, 32'd10);

    // UART frame of o = 10 at 4 clocks/bit, then the busy update is dropped
    wait_frame_start(1000, found);
    check("uart1_sync", {31'd0, found}, 32'd1);
    if (found) begin
      uart_rx(w, ok);
      check("uart1_word", w, 32'h0000000A);
      check("uart1_framing", {31'd0, ok}, 32'd1);
      bad = 1'b0;
      repeat (30) begin
        @(negedge clk);
        if (tx !== 1'b1) bad = 1'b1;
      end
      check("uart_drop_busy", {31'd0, bad}, 32'd0);
    end

    // Period rewrite mid-window
    wr(4'd1, 32'd50);
    repeat (60) @(negedge clk);
    check("period50_o", o, 32'd5);

    // Larger count for a richer UART word: rise every 4 clocks over 2000
    gen_half = 2;
    repeat (20) @(negedge clk);
    wr(4'd1, 32'd2000);
    found = 1'b0;
    for (int i = 0; i < 2200; i++) begin
      @(negedge clk);
      if (o == 32'd500) begin
        found = 1'b1;
        break;
      end
    end
    check("period2000_o", {31'd0, found}, 32'd1);
    wait_tx_low(5, found);
    check("uart2_start", {31'd0, found}, 32'd1);
    if (found) begin
      uart_rx(w, ok);
      check("uart2_word", w, 32'h000001F4);
      check("uart2_framing", {31'd0, ok}, 32'd1);
    end

    // Display mode 0 shows o
    run_display(1'b0);

    // Async reset during the second byte of the next frame
    wait_tx_low(2500, found);
    check("uart3_start", {31'd0, found}, 32'd1);
    repeat (50) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("arst_tx", {31'd0, tx}, 32'd1);
    check("arst_o", o, 32'd0);
    check("arst_oc", oc, 32'd0);
    check("arst_col", {23'd0, col_drvs}, 32'h001);
    check("arst_seg", {24'd0, seg_drvs}, 32'h3F);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check("post_rst_o", o, 32'd0);
    check("post_rst_tx", {31'd0, tx}, 32'd1);

    // Display mode 1 with custom digits and decimal points
    wr(4'd3, 32'h76543210);
    wr(4'd4, 32'd8);
    wr(4'd5, 32'h101);
    wr(4'd7, 32'hFFFFFFFF);
    wr(4'd2, 32'd1);
    run_display(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
